// File: rtl/axi_lite_ctrl_master.sv
// Single-outstanding AXI4-Lite initiator for a tile control port.
// Turns one cmd into one AXI-Lite write/read; keeps saturating debug counters.
module axi_lite_ctrl_master #(
    parameter int AXI_ADDR = 8,
    parameter int BW_AXI   = 32,
    parameter int BWB_AXI  = BW_AXI / 8,
    parameter int CNT_W    = 16
) (
    input  logic                clk_control,
    input  logic                clk_control_rst_low,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [AXI_ADDR-1:0] cmd_addr,
    input  logic [BW_AXI-1:0]   cmd_wdata,
    input  logic [BWB_AXI-1:0]  cmd_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_write,
    output logic [BW_AXI-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic [AXI_ADDR-1:0] m_AXI_AWADDR,
    output logic                m_AXI_AWVALID,
    input  logic                m_AXI_AWREADY,
    output logic [BW_AXI-1:0]   m_AXI_WDATA,
    output logic [BWB_AXI-1:0]  m_AXI_WSTRB,
    output logic                m_AXI_WVALID,
    input  logic                m_AXI_WREADY,
    input  logic [1:0]          m_AXI_BRESP,
    input  logic                m_AXI_BVALID,
    output logic                m_AXI_BREADY,
    output logic [AXI_ADDR-1:0] m_AXI_ARADDR,
    output logic                m_AXI_ARVALID,
    input  logic                m_AXI_ARREADY,
    input  logic [BW_AXI-1:0]   m_AXI_RDATA,
    input  logic [1:0]          m_AXI_RRESP,
    input  logic                m_AXI_RVALID,
    output logic                m_AXI_RREADY,
    output logic [CNT_W-1:0]    wr_count,
    output logic [CNT_W-1:0]    rd_count,
    output logic [CNT_W-1:0]    err_count
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t r_state;
    state_t w_next;

    logic                r_awvalid;
    logic                r_wvalid;
    logic                r_arvalid;
    logic                r_write;
    logic [AXI_ADDR-1:0] r_addr;
    logic [BW_AXI-1:0]   r_wdata;
    logic [BWB_AXI-1:0]  r_wstrb;
    logic [BW_AXI-1:0]   r_rdata;
    logic [1:0]          r_resp;
    logic [CNT_W-1:0]    r_wr_cnt;
    logic [CNT_W-1:0]    r_rd_cnt;
    logic [CNT_W-1:0]    r_err_cnt;

    logic w_cmd_hs;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_ar_hs;
    logic w_b_hs;
    logic w_r_hs;
    logic w_aw_done;
    logic w_w_done;
    logic w_err;

    assign w_cmd_hs  = cmd_valid && (r_state == IDLE);
    assign w_aw_hs   = r_awvalid && m_AXI_AWREADY;
    assign w_w_hs    = r_wvalid && m_AXI_WREADY;
    assign w_ar_hs   = r_arvalid && m_AXI_ARREADY;
    assign w_b_hs    = (r_state == WR_RESP) && m_AXI_BVALID;
    assign w_r_hs    = (r_state == RD_RESP) && m_AXI_RVALID;
    // A channel counts as done once its VALID has dropped or handshakes now
    assign w_aw_done = !r_awvalid || m_AXI_AWREADY;
    assign w_w_done  = !r_wvalid || m_AXI_WREADY;
    assign w_err     = (w_b_hs && (m_AXI_BRESP != 2'b00)) ||
                       (w_r_hs && (m_AXI_RRESP != 2'b00));

    always_ff @(posedge clk_control or negedge clk_control_rst_low) begin
        if (!clk_control_rst_low) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (cmd_valid) w_next = cmd_write ? WR_REQ : RD_REQ;
            WR_REQ:  if (w_aw_done && w_w_done) w_next = WR_RESP;
            WR_RESP: if (m_AXI_BVALID) w_next = RSP;
            RD_REQ:  if (m_AXI_ARREADY) w_next = RD_RESP;
            RD_RESP: if (m_AXI_RVALID) w_next = RSP;
            RSP:     if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_control or negedge clk_control_rst_low) begin
        if (!clk_control_rst_low) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_arvalid <= 1'b0;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
            r_resp    <= 2'b00;
        end else begin
            if (w_cmd_hs) begin
                r_write   <= cmd_write;
                r_addr    <= cmd_addr;
                r_wdata   <= cmd_wdata;
                r_wstrb   <= cmd_wstrb;
                r_awvalid <= cmd_write;
                r_wvalid  <= cmd_write;
                r_arvalid <= !cmd_write;
            end
            if (w_aw_hs) r_awvalid <= 1'b0;
            if (w_w_hs) r_wvalid <= 1'b0;
            if (w_ar_hs) r_arvalid <= 1'b0;
            if (w_b_hs) begin
                r_resp  <= m_AXI_BRESP;
                r_rdata <= '0;
            end
            if (w_r_hs) begin
                r_resp  <= m_AXI_RRESP;
                r_rdata <= m_AXI_RDATA;
            end
        end
    end

    always_ff @(posedge clk_control or negedge clk_control_rst_low) begin
        if (!clk_control_rst_low) begin
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_b_hs && (r_wr_cnt != CNT_MAX)) r_wr_cnt <= r_wr_cnt + CNT_ONE;
            if (w_r_hs && (r_rd_cnt != CNT_MAX)) r_rd_cnt <= r_rd_cnt + CNT_ONE;
            if (w_err && (r_err_cnt != CNT_MAX)) r_err_cnt <= r_err_cnt + CNT_ONE;
        end
    end

    assign cmd_ready     = (r_state == IDLE);
    assign rsp_valid     = (r_state == RSP);
    assign rsp_write     = r_write;
    assign rsp_rdata     = r_rdata;
    assign rsp_resp      = r_resp;
    assign m_AXI_AWADDR  = r_addr;
    assign m_AXI_AWVALID = r_awvalid;
    assign m_AXI_WDATA   = r_wdata;
    assign m_AXI_WSTRB   = r_wstrb;
    assign m_AXI_WVALID  = r_wvalid;
    assign m_AXI_BREADY  = (r_state == WR_RESP);
    assign m_AXI_ARADDR  = r_addr;
    assign m_AXI_ARVALID = r_arvalid;
    assign m_AXI_RREADY  = (r_state == RD_RESP);
    assign wr_count      = r_wr_cnt;
    assign rd_count      = r_rd_cnt;
    assign err_count     = r_err_cnt;

endmodule

// File: tb/tb_axi_lite_ctrl_master.sv
// Bench for axi_lite_ctrl_master: scripted AXI-Lite slave, cmd driver,
// and a response scoreboard fed at command acceptance.
module tb_axi_lite_ctrl_master;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [7:0]  m_AXI_AWADDR;
    logic        m_AXI_AWVALID;
    logic        m_AXI_AWREADY;
    logic [31:0] m_AXI_WDATA;
    logic [3:0]  m_AXI_WSTRB;
    logic        m_AXI_WVALID;
    logic        m_AXI_WREADY;
    logic [1:0]  m_AXI_BRESP;
    logic        m_AXI_BVALID;
    logic        m_AXI_BREADY;
    logic [7:0]  m_AXI_ARADDR;
    logic        m_AXI_ARVALID;
    logic        m_AXI_ARREADY;
    logic [31:0] m_AXI_RDATA;
    logic [1:0]  m_AXI_RRESP;
    logic        m_AXI_RVALID;
    logic        m_AXI_RREADY;
    logic [3:0]  wr_count;
    logic [3:0]  rd_count;
    logic [3:0]  err_count;

    axi_lite_ctrl_master #(
        .AXI_ADDR(8),
        .BW_AXI(32),
        .BWB_AXI(4),
        .CNT_W(4)
    ) dut (
        .clk_control(clk),
        .clk_control_rst_low(rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp),
        .m_AXI_AWADDR(m_AXI_AWADDR),
        .m_AXI_AWVALID(m_AXI_AWVALID),
        .m_AXI_AWREADY(m_AXI_AWREADY),
        .m_AXI_WDATA(m_AXI_WDATA),
        .m_AXI_WSTRB(m_AXI_WSTRB),
        .m_AXI_WVALID(m_AXI_WVALID),
        .m_AXI_WREADY(m_AXI_WREADY),
        .m_AXI_BRESP(m_AXI_BRESP),
        .m_AXI_BVALID(m_AXI_BVALID),
        .m_AXI_BREADY(m_AXI_BREADY),
        .m_AXI_ARADDR(m_AXI_ARADDR),
        .m_AXI_ARVALID(m_AXI_ARVALID),
        .m_AXI_ARREADY(m_AXI_ARREADY),
        .m_AXI_RDATA(m_AXI_RDATA),
        .m_AXI_RRESP(m_AXI_RRESP),
        .m_AXI_RVALID(m_AXI_RVALID),
        .m_AXI_RREADY(m_AXI_RREADY),
        .wr_count(wr_count),
        .rd_count(rd_count),
        .err_count(err_count)
    );

    typedef struct {
        logic        w;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    // slave script
    logic [7:0]  s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic [1:0]  s_bresp;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    int s_awdly = 0, s_wdly = 0, s_ardly = 0, s_bdly = 0;
    int rsp_hold_cfg = 0;

    // slave state
    int aw_wait, w_wait, ar_wait, b_wait;
    bit aw_seen, w_seen, ar_seen, aw_done, w_done, ar_done;
    bit b_arm, b_go, r_go;
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt, ar_vcyc, ar_vlast;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_rst();
        chk("rst_ctrl", {22'd0, cmd_ready, rsp_valid, rsp_write, rsp_resp,
            m_AXI_AWVALID, m_AXI_WVALID, m_AXI_BREADY, m_AXI_ARVALID,
            m_AXI_RREADY}, 32'h200);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_wdata", m_AXI_WDATA, 32'h0);
        chk("rst_addr", {12'd0, m_AXI_AWADDR, m_AXI_ARADDR, m_AXI_WSTRB}, 32'h0);
        chk("rst_cnt", {20'd0, wr_count, rd_count, err_count}, 32'h0);
    endtask

    task automatic chk_cnt(input logic [3:0] wr, input logic [3:0] rd,
                           input logic [3:0] er);
        chk("counters", {20'd0, wr_count, rd_count, err_count},
            {20'd0, wr, rd, er});
    endtask

    task automatic clr_hs();
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        ar_vlast = 0;
    endtask

    task automatic do_cmd(input logic w, input logic [7:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          input logic [31:0] erd, input logic [1:0] eresp,
                          input int lat);
        exp_t e;
        int n;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: cmd_ready=%0b want 1", cmd_ready);
            cmd_valid = 1'b0;
        end else begin
            e.w = w;
            e.rdata = erd;
            e.resp = eresp;
            e.lat = lat;
            e.acc = cyc;
            q.push_back(e);
            @(negedge clk);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((q.size() != 0 || !cmd_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (q.size() != 0 || !cmd_ready) begin
            bad++;
            $display("FAIL done_timeout: pending=%0d cmd_ready=%0b want 0/1",
                     q.size(), cmd_ready);
            q.delete();
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int lat);
        s_addr = a;
        s_wdata = d;
        s_wstrb = s;
        s_bresp = 2'b00;
        clr_hs();
        do_cmd(1'b1, a, d, s, 32'h0, 2'b00, lat);
        wait_done();
        chk("hs_count_wr", {8'd0, aw_cnt[7:0], w_cnt[7:0], b_cnt[7:0]},
            32'h00010101);
    endtask

    // AXI-Lite slave: drives at negedge, handshakes land on the next posedge
    initial begin
        m_AXI_AWREADY = 0; m_AXI_WREADY = 0; m_AXI_ARREADY = 0;
        m_AXI_BVALID = 0; m_AXI_BRESP = 0;
        m_AXI_RVALID = 0; m_AXI_RDATA = 0; m_AXI_RRESP = 0;
        aw_seen = 0; w_seen = 0; ar_seen = 0;
        aw_done = 0; w_done = 0; ar_done = 0;
        b_arm = 0; b_go = 0; r_go = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0;
        ar_vcyc = 0;
        clr_hs();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_AXI_AWREADY = 0; m_AXI_WREADY = 0; m_AXI_ARREADY = 0;
                m_AXI_BVALID = 0; m_AXI_RVALID = 0;
                aw_seen = 0; w_seen = 0; ar_seen = 0;
                aw_done = 0; w_done = 0; ar_done = 0;
                b_arm = 0; b_go = 0; r_go = 0;
            end else begin
                if (m_AXI_BVALID && b_go) begin
                    m_AXI_BVALID = 0;
                    b_cnt++;
                end
                if (aw_done && w_done) begin
                    aw_done = 0;
                    w_done = 0;
                    b_arm = 1;
                    b_wait = s_bdly;
                end
                if (b_arm && !m_AXI_BVALID) begin
                    if (b_wait == 0) begin
                        m_AXI_BVALID = 1;
                        m_AXI_BRESP = s_bresp;
                        b_arm = 0;
                    end else begin
                        b_wait--;
                    end
                end
                b_go = m_AXI_BVALID && m_AXI_BREADY;

                if (m_AXI_RVALID && r_go) begin
                    m_AXI_RVALID = 0;
                    r_cnt++;
                end
                if (ar_done) begin
                    ar_done = 0;
                    m_AXI_RVALID = 1;
                    m_AXI_RDATA = s_rdata;
                    m_AXI_RRESP = s_rresp;
                end
                r_go = m_AXI_RVALID && m_AXI_RREADY;

                if (m_AXI_AWVALID) begin
                    if (!aw_seen) begin
                        aw_seen = 1;
                        aw_wait = s_awdly;
                    end
                    chk("awaddr", {24'd0, m_AXI_AWADDR}, {24'd0, s_addr});
                    if (aw_wait > 0) begin
                        m_AXI_AWREADY = 0;
                        aw_wait--;
                    end else begin
                        m_AXI_AWREADY = 1;
                        aw_seen = 0;
                        aw_done = 1;
                        aw_cnt++;
                    end
                end else begin
                    m_AXI_AWREADY = 0;
                end

                if (m_AXI_WVALID) begin
                    if (!w_seen) begin
                        w_seen = 1;
                        w_wait = s_wdly;
                    end
                    chk("wdata", m_AXI_WDATA, s_wdata);
                    chk("wstrb", {28'd0, m_AXI_WSTRB}, {28'd0, s_wstrb});
                    if (w_wait > 0) begin
                        m_AXI_WREADY = 0;
                        w_wait--;
                    end else begin
                        m_AXI_WREADY = 1;
                        w_seen = 0;
                        w_done = 1;
                        w_cnt++;
                    end
                end else begin
                    m_AXI_WREADY = 0;
                end

                if (m_AXI_ARVALID) begin
                    if (!ar_seen) begin
                        ar_seen = 1;
                        ar_wait = s_ardly;
                        ar_vcyc = 0;
                    end
                    ar_vcyc++;
                    chk("araddr", {24'd0, m_AXI_ARADDR}, {24'd0, s_addr});
                    if (ar_wait > 0) begin
                        m_AXI_ARREADY = 0;
                        ar_wait--;
                    end else begin
                        m_AXI_ARREADY = 1;
                        ar_seen = 0;
                        ar_done = 1;
                        ar_cnt++;
                        ar_vlast = ar_vcyc;
                    end
                end else begin
                    m_AXI_ARREADY = 0;
                end
            end
        end
    end

    // response monitor / scoreboard
    initial begin
        bit m_seen;
        int m_hold;
        exp_t e;
        m_seen = 0;
        m_hold = 0;
        rsp_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_seen = 0;
                rsp_ready = (rsp_hold_cfg == 0);
            end else if (rsp_valid) begin
                if (!m_seen) begin
                    m_seen = 1;
                    m_hold = rsp_hold_cfg;
                end
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_unexpected: rsp_valid=1 want 0");
                end else if (m_hold > 0) begin
                    m_hold--;
                    rsp_ready = 1'b0;
                    chk("hold_rdata", rsp_rdata, q[0].rdata);
                    chk("hold_fields", {28'd0, cmd_ready, rsp_write, rsp_resp},
                        {28'd0, 1'b0, q[0].w, q[0].resp});
                end else begin
                    rsp_ready = 1'b1;
                    e = q.pop_front();
                    m_seen = 0;
                    chk("rsp_write", {31'd0, rsp_write}, {31'd0, e.w});
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_resp", {30'd0, rsp_resp}, {30'd0, e.resp});
                    if (e.lat >= 0) chk("latency", cyc - e.acc, e.lat);
                end
            end else begin
                rsp_ready = (rsp_hold_cfg == 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: sim time %0t exceeded", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr = 8'h0;
        cmd_wdata = 32'h0;
        cmd_wstrb = 4'h0;
        s_addr = 0; s_wdata = 0; s_wstrb = 0;
        s_bresp = 0; s_rdata = 0; s_rresp = 0;
        repeat (3) @(negedge clk);
        chk_rst();
        #2 rst_n = 1'b1;

        // zero-wait write
        wr(8'h10, 32'hDEADBEEF, 4'hF, 3);
        chk_cnt(4'd1, 4'd0, 4'd0);

        // read with ARREADY held low 3 cycles
        s_addr = 8'h04; s_rdata = 32'h7; s_rresp = 2'b00; s_ardly = 3;
        clr_hs();
        do_cmd(1'b0, 8'h04, 32'h0, 4'h0, 32'h7, 2'b00, 6);
        wait_done();
        chk("ar_valid_cycles", ar_vlast, 4);
        chk("hs_count_rd", {16'd0, ar_cnt[7:0], r_cnt[7:0]}, 32'h0101);
        chk_cnt(4'd1, 4'd1, 4'd0);

        // zero-wait read
        s_addr = 8'h08; s_rdata = 32'h12345678; s_ardly = 0;
        do_cmd(1'b0, 8'h08, 32'h0, 4'h0, 32'h12345678, 2'b00, 3);
        wait_done();
        chk_cnt(4'd1, 4'd2, 4'd0);

        // W before AW, AW before W, both together
        s_awdly = 2; s_wdly = 0;
        wr(8'h20, 32'h11223344, 4'h3, 5);
        s_awdly = 0; s_wdly = 2;
        wr(8'h24, 32'hA5A5A5A5, 4'hC, 5);
        s_awdly = 2; s_wdly = 2;
        wr(8'h28, 32'h0BADF00D, 4'h1, 5);
        s_awdly = 0; s_wdly = 0;
        chk_cnt(4'd4, 4'd2, 4'd0);

        // error read with response held off
        s_addr = 8'h0C; s_rdata = 32'hCAFE0001; s_rresp = 2'b10;
        rsp_hold_cfg = 5;
        do_cmd(1'b0, 8'h0C, 32'h0, 4'h0, 32'hCAFE0001, 2'b10, 8);
        wait_done();
        rsp_hold_cfg = 0;
        s_rresp = 2'b00;
        chk_cnt(4'd4, 4'd3, 4'd1);

        // reset while waiting in WR_RESP
        s_bdly = 1000;
        s_addr = 8'h40; s_wdata = 32'h55AA55AA; s_wstrb = 4'hF;
        do_cmd(1'b1, 8'h40, 32'h55AA55AA, 4'hF, 32'h0, 2'b00, -1);
        n = 0;
        while (!m_AXI_BREADY && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bready_before_rst", {31'd0, m_AXI_BREADY}, 32'h1);
        #2 rst_n = 1'b0;
        #1 chk_rst();
        q.delete();
        s_bdly = 0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("cmd_ready_after_rst", {31'd0, cmd_ready}, 32'h1);
        wr(8'h30, 32'h600DCAFE, 4'hF, 3);
        chk_cnt(4'd1, 4'd0, 4'd0);

        // saturate wr_count at 0xF
        for (int i = 0; i < 16; i++) begin
            wr(8'h44, 32'h100 + i, 4'hF, 3);
            chk("wr_count_sat", {28'd0, wr_count},
                (i + 2 > 15) ? 32'd15 : i + 2);
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
